// File: rtl/if_id_stage_reg_pkg.sv
// Shared IF/ID definitions: FSM encoding, NOP, field positions.
// Imported by the IF/ID register and its skid buffer.
package if_id_stage_reg_pkg;

    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_DEFAULT  = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_SQUASH = 2'd2
    } state_e;

    localparam int RD_LSB  = 7;
    localparam int OPC_LSB = 2;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

endpackage

// File: rtl/if_id_stage_reg_skid.sv
// One-entry {instr,pc} holding register for IMEM responses
// that arrive while decode is stalled.
import if_id_stage_reg_pkg::*;

module if_id_stage_reg_skid #(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            load,
    input  logic            clear,
    input  logic [31:0]     load_instr,
    input  logic [XLEN-1:0] load_pc,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic            full
);

    // Clear wins over load; a full entry is never overwritten.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            full  <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load && !full) begin
            full  <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register with stall skid and post-flush squash.
// Optional counters: define IF_ID_STALL_CNT_EN.
import if_id_stage_reg_pkg::*;

module if_id_stage_reg #(
    parameter int          XLEN      = XLEN_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [31:0]     instr_i,
    input  logic            instr_valid_i,
    input  logic [XLEN-1:0] pc_IF_i,
    input  logic            hazard_stall_i,
    input  logic            flush_i,
    output logic [31:0]     instr_ID_o,
    output logic [XLEN-1:0] pc_ID_o,
    output logic            valid_ID_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [4:0]      opcode_o,
    output logic [2:0]      funct3_o,
    output logic            stall_IF_o,
    output logic [31:0]     stall_cnt_o,
    output logic [31:0]     flush_cnt_o
);

    state_e state_q, state_d;

    logic            skid_load, skid_clear, skid_full;
    logic [31:0]     skid_instr;
    logic [XLEN-1:0] skid_pc;

    logic id_kill, id_load_fetch, id_load_skid;

    if_id_stage_reg_skid #(.XLEN(XLEN)) u_skid (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load       (skid_load),
        .clear      (skid_clear),
        .load_instr (instr_i),
        .load_pc    (pc_IF_i),
        .instr      (skid_instr),
        .pc         (skid_pc),
        .full       (skid_full)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (!reset_i) state_q <= ST_RUN;
        else          state_q <= state_d;
    end

    // Next state: flush beats stall in every state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (flush_i)
                    state_d = ST_SQUASH;
                else if (hazard_stall_i && instr_valid_i)
                    state_d = ST_STALL;
            end
            ST_STALL: begin
                if (flush_i)              state_d = ST_SQUASH;
                else if (!hazard_stall_i) state_d = ST_RUN;
            end
            ST_SQUASH: begin
                state_d = flush_i ? ST_SQUASH : ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Per-state control for the ID register and skid.
    always_comb begin
        stall_IF_o    = 1'b0;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;
        id_kill       = 1'b0;
        id_load_fetch = 1'b0;
        id_load_skid  = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                stall_IF_o    = hazard_stall_i;
                id_kill       = flush_i;
                skid_load     = !flush_i && hazard_stall_i
                              && instr_valid_i;
                id_load_fetch = !flush_i && !hazard_stall_i;
            end
            ST_STALL: begin
                stall_IF_o   = 1'b1;
                id_kill      = flush_i;
                skid_clear   = flush_i || !hazard_stall_i;
                id_load_skid = !flush_i && !hazard_stall_i;
            end
            ST_SQUASH: begin
                id_kill = 1'b1;
            end
            default: begin
                id_kill = 1'b1;
            end
        endcase
    end

    // ID register; pc is left alone when killed or held.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            instr_ID_o <= NOP_INSTR;
            pc_ID_o    <= '0;
            valid_ID_o <= 1'b0;
        end else if (id_kill) begin
            instr_ID_o <= NOP_INSTR;
            valid_ID_o <= 1'b0;
        end else if (id_load_skid) begin
            instr_ID_o <= skid_instr;
            pc_ID_o    <= skid_pc;
            valid_ID_o <= 1'b1;
        end else if (id_load_fetch) begin
            instr_ID_o <= instr_valid_i ? instr_i : NOP_INSTR;
            pc_ID_o    <= pc_IF_i;
            valid_ID_o <= instr_valid_i;
        end
    end

    assign rs1_o    = instr_ID_o[RS1_LSB +: 5];
    assign rs2_o    = instr_ID_o[RS2_LSB +: 5];
    assign rd_o     = instr_ID_o[RD_LSB  +: 5];
    assign opcode_o = instr_ID_o[OPC_LSB +: 5];
    assign funct3_o = instr_ID_o[F3_LSB  +: 3];

`ifdef IF_ID_STALL_CNT_EN
    // Saturating stall-cycle and flush-event counters.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_IF_o && stall_cnt_o != 32'hFFFF_FFFF)
                stall_cnt_o <= stall_cnt_o + 32'd1;
            if (flush_i && flush_cnt_o != 32'hFFFF_FFFF)
                flush_cnt_o <= flush_cnt_o + 32'd1;
        end
    end
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Scoreboard bench for if_id_stage_reg: directed cases then
// random traffic against a cycle-level behavioural model.
module tb_if_id_stage_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic [31:0] instr_i = '0;
    logic        instr_valid_i = 1'b0;
    logic [31:0] pc_IF_i = '0;
    logic        hazard_stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] instr_ID_o, pc_ID_o;
    logic        valid_ID_o, stall_IF_o;
    logic [4:0]  rs1_o, rs2_o, rd_o, opcode_o;
    logic [2:0]  funct3_o;
    logic [31:0] stall_cnt_o, flush_cnt_o;

    always #5 clk = ~clk;

    if_id_stage_reg dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .instr_i        (instr_i),
        .instr_valid_i  (instr_valid_i),
        .pc_IF_i        (pc_IF_i),
        .hazard_stall_i (hazard_stall_i),
        .flush_i        (flush_i),
        .instr_ID_o     (instr_ID_o),
        .pc_ID_o        (pc_ID_o),
        .valid_ID_o     (valid_ID_o),
        .rs1_o          (rs1_o),
        .rs2_o          (rs2_o),
        .rd_o           (rd_o),
        .opcode_o       (opcode_o),
        .funct3_o       (funct3_o),
        .stall_IF_o     (stall_IF_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: visible ID slot, pending held responses,
    // and whether the next fetch response must be thrown away.
    logic [31:0] m_instr = NOP;
    logic [31:0] m_pc = '0;
    logic        m_valid = 1'b0;
    logic [63:0] m_held[$];
    bit          m_drop_next = 0;
    int unsigned m_sc = 0;
    int unsigned m_fc = 0;

    function automatic logic m_stall_if(input logic st);
        return !m_drop_next && (st || m_held.size() != 0);
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic [31:0] ins,
                              input logic iv, input logic [31:0] p,
                              input logic st, input logic fl);
        logic [63:0] e;
        if (!r) begin
            m_instr = NOP; m_pc = '0; m_valid = 0;
            m_held.delete(); m_drop_next = 0; m_sc = 0; m_fc = 0;
            return;
        end
        if (m_stall_if(st) && m_sc != 32'hFFFF_FFFF) m_sc++;
        if (fl && m_fc != 32'hFFFF_FFFF) m_fc++;
        if (m_drop_next || fl) begin
            m_held.delete();
            m_instr = NOP; m_valid = 0;
            m_drop_next = fl;
        end else if (m_held.size() != 0) begin
            if (!st) begin
                e = m_held.pop_front();
                m_instr = e[63:32]; m_pc = e[31:0]; m_valid = 1;
            end
        end else if (st) begin
            if (iv) m_held.push_back({ins, p});
        end else begin
            m_instr = iv ? ins : NOP; m_pc = p; m_valid = iv;
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] ins,
                         input logic iv, input logic [31:0] p,
                         input logic st, input logic fl);
        exp_t x;
        @(negedge clk);
        reset_i = r; instr_i = ins; instr_valid_i = iv;
        pc_IF_i = p; hazard_stall_i = st; flush_i = fl;
        #1;
        check("stall_IF", stall_IF_o, m_stall_if(st));
        model_step(r, ins, iv, p, st, fl);
        x.instr = m_instr; x.pc = m_pc; x.valid = m_valid;
`ifdef IF_ID_STALL_CNT_EN
        x.sc = m_sc; x.fc = m_fc;
`else
        x.sc = 0; x.fc = 0;
`endif
        exp_q.push_back(x);
    endtask

    // Monitor: after each edge, compare DUT outputs with the queue head.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                check("instr_ID", instr_ID_o, x.instr);
                check("valid_ID", valid_ID_o, x.valid);
                check("pc_ID", pc_ID_o, x.pc);
                check("rs1", rs1_o, x.instr[19:15]);
                check("rs2", rs2_o, x.instr[24:20]);
                check("rd", rd_o, x.instr[11:7]);
                check("opcode", opcode_o, x.instr[6:2]);
                check("funct3", funct3_o, x.instr[14:12]);
                check("stall_cnt", stall_cnt_o, x.sc);
                check("flush_cnt", flush_cnt_o, x.fc);
            end
        end
    end

    initial begin
        int wait_cyc;
        logic [31:0] exp_sc, exp_fc;
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        // straight-line
        drive(1, 32'h0050_0093, 1, 32'h100, 0, 0);
        drive(1, 32'h0010_8133, 1, 32'h104, 0, 0);
        drive(1, 0, 0, 32'h108, 0, 0);
        // stall with a response landing in the skid
        drive(1, 32'h0040_0213, 1, 32'h108, 0, 0);
        drive(1, 32'h0020_8193, 1, 32'h10c, 1, 0);
        drive(1, 32'hdead_beef, 1, 32'h110, 1, 0);
        drive(1, 32'hdead_beef, 1, 32'h110, 0, 0);
        drive(1, 32'h0030_0293, 1, 32'h110, 0, 0);
        // flush, dropped response, accepted response
        drive(1, 32'h0000_0000, 0, 32'h114, 0, 1);
        drive(1, 32'h00a0_0313, 1, 32'h114, 0, 0);
        drive(1, 32'h00b0_0393, 1, 32'h200, 0, 0);
        // flush + stall together while in STALL
        drive(1, 32'h00c0_0413, 1, 32'h204, 1, 0);
        drive(1, 32'h00d0_0493, 1, 32'h208, 1, 1);
        drive(1, 32'h00e0_0513, 1, 32'h208, 1, 0);
        drive(1, 32'h00f0_0593, 1, 32'h300, 0, 0);
        // reset while stalled
        drive(1, 32'h0100_0613, 1, 32'h304, 1, 0);
        drive(0, 32'h0110_0693, 1, 32'h308, 1, 0);
        drive(1, 32'h0120_0713, 1, 32'h400, 0, 0);
        // counters: 5 stall cycles and 2 flushes after reset
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(1, 0, 0, 32'h500, 1, 0);
        drive(1, 0, 0, 32'h500, 0, 1);
        drive(1, 0, 0, 32'h500, 0, 1);
        drive(1, 0, 0, 32'h500, 0, 0);
        @(posedge clk); #2;
`ifdef IF_ID_STALL_CNT_EN
        exp_sc = 5; exp_fc = 2;
`else
        exp_sc = 0; exp_fc = 0;
`endif
        check("stall_cnt_dir", stall_cnt_o, exp_sc);
        check("flush_cnt_dir", flush_cnt_o, exp_fc);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 59) != 0, $urandom,
                  $urandom_range(0, 3) != 0, $urandom,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0);
        end
        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 10) begin
            @(posedge clk); #3;
            wait_cyc++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
